// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int unsigned HDR_BYTES         = 2;
  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned DEFAULT_MAX_WORDS = 1024;

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs a byte stream into big-endian 32-bit words and flags each completed word.
module program_loader_word_packer
  import program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        shift,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_full
);

  // Shift bytes in MSB first; word_full pulses the cycle after the 4th byte
  // lands, when word holds the complete instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      word      <= '0;
      byte_idx  <= '0;
      word_full <= 1'b0;
    end else begin
      word_full <= shift && (byte_idx == 2'(WORD_BYTES - 1));
      if (shift) begin
        word     <= {word[23:0], data};
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: header / payload / checksum stream into instruction memory,
// holding the CPU in reset until a complete, checksum-clean image is written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int unsigned IMEM_AW   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_nreset,
  output logic               done,
  output logic               error
);

  state_t      state;
  state_t      state_nx;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [7:0]  sum;
  logic [15:0] hdr_count;
  logic [1:0]  byte_idx;
  logic        word_full;
  logic [31:0] packed_word;
  logic        xfer;
  logic        last_byte;
  logic        last_word;
  logic        shift;

  assign xfer      = in_valid && in_ready;
  assign hdr_count = {count[15:8], in_data};
  assign last_byte = (byte_idx == 2'(WORD_BYTES - 1));
  assign last_word = ((word_idx + 16'd1) == count);
  assign shift     = xfer && (state == PAYLOAD);

  program_loader_word_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .data      (in_data),
    .shift     (shift),
    .word      (packed_word),
    .byte_idx  (byte_idx),
    .word_full (word_full)
  );

  // The packer's registered word and pulse are the memory write port directly.
  assign imem_we    = word_full;
  assign imem_wdata = packed_word;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= HDR_HI;
    else       state <= state_nx;
  end

  // Next-state logic; the last payload word moves to CHECK at its 4th byte,
  // and the write bubble keeps the trailer from being taken before the write.
  always_comb begin
    state_nx = state;
    case (state)
      HDR_HI:  if (xfer) state_nx = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (32'(hdr_count) > MAX_WORDS) state_nx = ERROR;
          else if (hdr_count == 16'd0)    state_nx = CHECK;
          else                            state_nx = PAYLOAD;
        end
      end
      PAYLOAD: if (xfer && last_byte && last_word) state_nx = CHECK;
      CHECK:   if (xfer) state_nx = (in_data == sum) ? DONE : ERROR;
      DONE:    state_nx = DONE;
      ERROR:   state_nx = ERROR;
      default: state_nx = ERROR;
    endcase
  end

  // Handshake: accept only in loading states, never during a write or reset.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && !word_full &&
        (state == HDR_HI || state == HDR_LO || state == PAYLOAD || state == CHECK))
      in_ready = 1'b1;
  end

  // Header count, payload checksum, word index and write address.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      word_idx  <= '0;
      sum       <= '0;
      imem_addr <= '0;
    end else if (xfer) begin
      case (state)
        HDR_HI: count[15:8] <= in_data;
        HDR_LO: count[7:0]  <= in_data;
        PAYLOAD: begin
          sum <= sum + in_data;
          if (last_byte) begin
            imem_addr <= IMEM_AW'({word_idx, 2'b00});
            word_idx  <= word_idx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky status flags, registered so they rise the cycle after the deciding byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_nreset <= 1'b0;
    end else begin
      done       <= (state_nx == DONE);
      error      <= (state_nx == ERROR);
      cpu_nreset <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed streams against a byte-list reference model.
module tb_program_loader;

  localparam int unsigned MAXW = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_nreset;
  logic        done;
  logic        error;

  program_loader #(.MAX_WORDS(MAXW), .IMEM_AW(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_nreset (cpu_nreset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] stim[$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         exp_done;
  bit         exp_err;
  bit         complete;
  int         n_accept;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      check_eq("we_bubble", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", {31'd0, imem_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", imem_addr, mon_e.addr);
        check_eq("wr_data", imem_wdata, mon_e.data);
      end
    end
  end

  // Reference model: derive writes, acceptance length and final status from the byte list.
  task automatic build_model();
    int n;
    logic [7:0] s;
    wr_t w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    complete = 1'b0;
    s = 8'd0;
    if (stim.size() < 2) begin
      n_accept = stim.size();
      return;
    end
    n = int'({stim[0], stim[1]});
    if (n > int'(MAXW)) begin
      exp_err  = 1'b1;
      complete = 1'b1;
      n_accept = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (2 + 4*i + 3 < stim.size()) begin
        w.addr = 32'(4*i);
        w.data = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
        exp_q.push_back(w);
      end
    end
    for (int j = 2; j < 2 + 4*n && j < stim.size(); j++) s = s + stim[j];
    if (stim.size() > 2 + 4*n) begin
      complete = 1'b1;
      n_accept = 2 + 4*n + 1;
      exp_done = (stim[2+4*n] == s);
      exp_err  = !exp_done;
    end else begin
      n_accept = stim.size();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_we", {31'd0, imem_we}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_nreset", {31'd0, cpu_nreset}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_rst", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (in_ready !== 1'b1) check_eq("handshake_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic reject_check(input int n);
    in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_data = 8'($urandom);
      #1;
      check_eq("reject_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check_eq("held_done", {31'd0, done}, {31'd0, exp_done});
    check_eq("held_error", {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic run_stream(input int drop_idx, input int drop_len);
    int gap;
    build_model();
    for (int i = 0; i < n_accept; i++) begin
      if (i == drop_idx) gap = drop_len;
      else gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_byte(stim[i], gap);
    end
    if (complete) begin
      check_eq("done", {31'd0, done}, {31'd0, exp_done});
      check_eq("error", {31'd0, error}, {31'd0, exp_err});
      check_eq("cpu_nreset", {31'd0, cpu_nreset}, {31'd0, exp_done});
      check_eq("writes_left", 32'(exp_q.size()), 32'd0);
      reject_check(20);
    end
  endtask

  task automatic gen_random(input int forced_n);
    int n;
    logic [7:0] b;
    logic [7:0] s;
    bit bad;
    stim.delete();
    s = 8'd0;
    bad = ($urandom_range(0, 3) == 0);
    if (forced_n >= 0) n = forced_n;
    else if ($urandom_range(0, 5) == 0) n = int'(MAXW) + 1 + int'($urandom_range(0, 60000));
    else n = int'($urandom_range(0, 6));
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    if (n > int'(MAXW)) begin
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
      return;
    end
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      s = s + b;
    end
    stim.push_back(bad ? 8'(s + 8'($urandom_range(1, 255))) : s);
  endtask

  initial begin
    do_reset();
    stim = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    run_stream(-1, 0);

    do_reset();
    stim = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'hAC, 8'h01, 8'h00, 8'h04, 8'h3E};
    run_stream(4, 3);

    do_reset();
    stim = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_stream(-1, 0);

    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    run_stream(-1, 0);

    do_reset();
    stim = '{8'h04, 8'h01, 8'hAA, 8'h55};
    run_stream(-1, 0);

    do_reset();
    stim = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'hAC, 8'h01};
    run_stream(-1, 0);
    do_reset();
    check_eq("partial_writes", 32'(exp_q.size()), 32'd0);
    stim = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'hAC, 8'h01, 8'h00, 8'h04, 8'h3E};
    run_stream(-1, 0);

    do_reset();
    gen_random(int'(MAXW));
    run_stream(-1, 0);

    for (int t = 0; t < 12; t++) begin
      do_reset();
      gen_random(-1);
      run_stream(-1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
